// File: rtl/jtvigil_mainio_if.sv
// Z80 I/O bus bundle between the CPU wrapper and jtvigil_mainio.
//   A       : address low byte (I/O port number)
//   iorq_n, rd_n, wr_n, m1_n : bus strobes
//   din     : CPU data out
//   dout    : registered I/O read data
// master = CPU side, slave = I/O block side.
interface jtvigil_mainio_if;
  logic [7:0] A;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output A, iorq_n, rd_n, wr_n, m1_n, din, input dout);
  modport slave  (input A, iorq_n, rd_n, wr_n, m1_n, din, output dout);
endinterface

// File: rtl/jtvigil_mainio.sv
// Main-CPU I/O port block for Z80 Irem-style boards.
// Decodes Z80 I/O cycles into a sound latch, flip/coin control, ROM bank,
// LAYERS double-buffered scroll registers and a colour/enable register, and
// raises the vblank interrupt (cleared by acknowledge or after INTLEN cen pulses).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cen          : CPU clock enable (interrupt auto-clear counter only)
//   bus          : Z80 I/O bus (A, strobes, din, dout)
//   LVBL         : active-low vertical blank
//   dip_pause    : low blocks new interrupt requests
//   int_n        : Z80 maskable interrupt
//   cab_in       : five cabinet read ports, byte k = port k
//   snd_latch/snd_wr : sound command and one-clk write strobe
//   flip, flip_dip   : screen flip (register XOR DIP)
//   coin_cnt, bank, scrpos, scrcol : control registers
module jtvigil_mainio #(
  parameter int BANKW   = 3,
  parameter int LAYERS  = 2,
  parameter int SCRW    = 11,
  parameter int VBLATCH = 1,
  parameter int INTLEN  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  jtvigil_mainio_if.slave          bus,
  input  logic                     LVBL,
  input  logic                     dip_pause,
  output logic                     int_n,
  input  logic [39:0]              cab_in,
  output logic [7:0]               snd_latch,
  output logic                     snd_wr,
  output logic                     flip,
  input  logic                     flip_dip,
  output logic [1:0]               coin_cnt,
  output logic [BANKW-1:0]         bank,
  output logic [LAYERS*SCRW-1:0]   scrpos,
  output logic [7:0]               scrcol
);

  localparam int CNTW = (INTLEN > 1) ? $clog2(INTLEN) : 1;

  logic            wr_hit, rd_hit, ack, wr_ev, wr_l;
  logic            lvbl_l, vb_edge;
  logic            lo_port;
  logic [2:0]      lo_sel;
  logic [6:0]      hi_idx;
  logic [7:0]      rd_val;
  logic            flip_r;
  logic [CNTW-1:0] icnt;
  logic [SCRW-1:0] shadow    [LAYERS];
  logic [SCRW-1:0] shadow_nx [LAYERS];

  assign wr_hit  = ~bus.iorq_n & ~bus.wr_n & bus.m1_n;
  assign rd_hit  = ~bus.iorq_n & ~bus.rd_n & bus.m1_n;
  assign ack     = ~bus.iorq_n & ~bus.m1_n;
  // One update per bus cycle however long the wait states last
  assign wr_ev   = wr_hit & ~wr_l;
  assign vb_edge = lvbl_l & ~LVBL;
  // Low ports decode only A[2:0]; A[6:3] are don't-care when A[7]=0
  assign lo_port = ~bus.A[7];
  assign lo_sel  = bus.A[2:0];
  assign hi_idx  = bus.A[6:0];
  assign flip    = flip_r ^ flip_dip;

  always_comb begin
    rd_val = 8'hFF;
    if (lo_port) begin
      case (lo_sel)
        3'd0:    rd_val = cab_in[7:0];
        3'd1:    rd_val = cab_in[15:8];
        3'd2:    rd_val = cab_in[23:16];
        3'd3:    rd_val = cab_in[31:24];
        3'd4:    rd_val = cab_in[39:32];
        default: rd_val = 8'hFF;
      endcase
    end
  end

  // Next shadow value is also what gets latched on the vblank edge, so a
  // write landing on that same clk is carried into scrpos.
  always_comb begin
    shadow_nx = shadow;
    if (wr_ev && bus.A[7]) begin
      for (int unsigned k = 0; k < LAYERS; k++) begin
        if (hi_idx == 7'(2*k))   shadow_nx[k][7:0]      = bus.din;
        if (hi_idx == 7'(2*k+1)) shadow_nx[k][SCRW-1:8] = bus.din[SCRW-9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_l      <= 1'b0;
      lvbl_l    <= 1'b1;
      bus.dout  <= 8'hFF;
      snd_latch <= '0;
      snd_wr    <= 1'b0;
      flip_r    <= 1'b0;
      coin_cnt  <= '0;
      bank      <= '0;
      scrcol    <= '0;
      for (int unsigned k = 0; k < LAYERS; k++) shadow[k] <= '0;
    end else begin
      wr_l   <= wr_hit;
      lvbl_l <= LVBL;
      snd_wr <= 1'b0;
      shadow <= shadow_nx;
      if (wr_ev) begin
        if (lo_port) begin
          case (lo_sel)
            3'd0: begin
              snd_latch <= bus.din;
              snd_wr    <= 1'b1;
            end
            3'd1: begin
              flip_r   <= bus.din[0];
              coin_cnt <= bus.din[2:1];
            end
            3'd4:    bank <= bus.din[BANKW-1:0];
            default: ;
          endcase
        end else if (hi_idx == 7'(2*LAYERS)) begin
          scrcol <= bus.din;
        end
      end
      if (rd_hit) bus.dout <= rd_val;
    end
  end

  generate
    if (VBLATCH != 0) begin : g_latch
      logic [LAYERS*SCRW-1:0] act;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          act <= '0;
        end else if (vb_edge) begin
          for (int unsigned k = 0; k < LAYERS; k++) act[k*SCRW +: SCRW] <= shadow_nx[k];
        end
      end
      assign scrpos = act;
    end else begin : g_direct
      always_comb begin
        scrpos = '0;
        for (int unsigned k = 0; k < LAYERS; k++) scrpos[k*SCRW +: SCRW] = shadow[k];
      end
    end
  endgenerate

  // A new vblank request outranks an acknowledge in the same clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_n <= 1'b1;
      icnt  <= '0;
    end else if (vb_edge && dip_pause) begin
      int_n <= 1'b0;
      icnt  <= '0;
    end else if (ack) begin
      int_n <= 1'b1;
      icnt  <= '0;
    end else if (INTLEN > 0 && !int_n && cen) begin
      if (icnt == CNTW'(INTLEN-1)) begin
        int_n <= 1'b1;
        icnt  <= '0;
      end else begin
        icnt <= icnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtvigil_mainio.sv
module tb_jtvigil_mainio;
  localparam int BANKW = 3, LAYERS = 2, SCRW = 11;

  logic clk = 1'b0, rst = 1'b1, cen = 1'b0;
  logic LVBL = 1'b1, dip_pause = 1'b1, flip_dip = 1'b0;
  logic int_n, snd_wr, flip;
  logic [39:0] cab_in = {8'h44, 8'h33, 8'h5A, 8'h22, 8'h11};
  logic [7:0] snd_latch, scrcol;
  logic [1:0] coin_cnt;
  logic [BANKW-1:0] bank;
  logic [LAYERS*SCRW-1:0] scrpos;

  jtvigil_mainio_if bus();

  jtvigil_mainio #(.BANKW(BANKW), .LAYERS(LAYERS), .SCRW(SCRW), .VBLATCH(1), .INTLEN(8)) dut (
    .clk(clk), .rst(rst), .cen(cen), .bus(bus), .LVBL(LVBL), .dip_pause(dip_pause),
    .int_n(int_n), .cab_in(cab_in), .snd_latch(snd_latch), .snd_wr(snd_wr),
    .flip(flip), .flip_dip(flip_dip), .coin_cnt(coin_cnt), .bank(bank),
    .scrpos(scrpos), .scrcol(scrcol));

  always #5 clk = ~clk;

  typedef enum int {S_BANK, S_SND, S_SNDWR, S_DOUT, S_INT, S_FLIP, S_COIN, S_SCR0, S_SCR1, S_COL} sig_e;
  typedef struct { int cyc; sig_e sig; logic [15:0] val; } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  checks = 0, passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(sig_e s);
    case (s)
      S_BANK:  return 16'(bank);
      S_SND:   return 16'(snd_latch);
      S_SNDWR: return 16'(snd_wr);
      S_DOUT:  return 16'(bus.dout);
      S_INT:   return 16'(int_n);
      S_FLIP:  return 16'(flip);
      S_COIN:  return 16'(coin_cnt);
      S_SCR0:  return 16'(scrpos[0 +: SCRW]);
      S_SCR1:  return 16'(scrpos[SCRW +: SCRW]);
      default: return 16'(scrcol);
    endcase
  endfunction

  // Monitor: compares every expectation that falls due on this cycle
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        logic [15:0] a;
        a = actual(sbq[i].sig);
        checks++;
        if (a === sbq[i].val) passes++;
        else $display("FAIL %s cyc %0d: got %h want %h", sbq[i].sig.name(), cyc, a, sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic exp_at(sig_e s, logic [15:0] v, int d);
    sb_t e;
    e.cyc = cyc + d; e.sig = s; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.m1_n = 1'b1;
  endtask

  task automatic io_write(logic [7:0] a, logic [7:0] d, int len);
    bus.A = a; bus.din = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick(len);
    bus_idle();
    tick(1);
  endtask

  task automatic io_read(logic [7:0] a, int len);
    bus.A = a; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    tick(len);
    bus_idle();
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    bus_idle();
    bus.A = '0; bus.din = '0;
    tick(2);
    // Reset values
    exp_at(S_DOUT, 16'hFF, 0); exp_at(S_INT, 16'h1, 0); exp_at(S_BANK, 16'h0, 0);
    exp_at(S_SND, 16'h0, 0);   exp_at(S_SCR0, 16'h0, 0); exp_at(S_COL, 16'h0, 0);
    exp_at(S_FLIP, 16'h0, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Bank write with wait states; din changes mid-cycle and must be ignored
    exp_at(S_BANK, 16'h5, 1); exp_at(S_BANK, 16'h5, 4);
    bus.A = 8'h04; bus.din = 8'h05; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick(2);
    bus.din = 8'h02;
    tick(3);
    bus_idle();
    tick(1);
    exp_at(S_BANK, 16'h5, 0);
    tick(1);
    exp_at(S_BANK, 16'h7, 1);
    io_write(8'h04, 8'hFF, 1);
    checks++;
    if (bank === 3'd7) passes++;
    else $display("FAIL bank direct: got %h want 7", bank);

    // Sound latch: strobe high for exactly one clk
    exp_at(S_SNDWR, 16'h0, 0);
    exp_at(S_SND, 16'h3C, 1); exp_at(S_SNDWR, 16'h1, 1);
    exp_at(S_SNDWR, 16'h0, 2); exp_at(S_SNDWR, 16'h0, 3); exp_at(S_SNDWR, 16'h0, 4);
    io_write(8'h00, 8'h3C, 4);
    checks++;
    if (snd_latch === 8'h3C) passes++;
    else $display("FAIL snd_latch direct: got %h want 3C", snd_latch);

    // Reads
    exp_at(S_DOUT, 16'h5A, 1); io_read(8'h02, 2);
    checks++;
    if (bus.dout === 8'h5A) passes++;
    else $display("FAIL dout direct: got %h want 5A", bus.dout);
    exp_at(S_DOUT, 16'hFF, 1); io_read(8'h07, 1);
    exp_at(S_DOUT, 16'h44, 1); io_read(8'h0C, 1);
    exp_at(S_DOUT, 16'hFF, 1); io_read(8'h84, 1);

    // Colour register and scroll shadows mid-frame
    exp_at(S_COL, 16'hA5, 1); io_write(8'h84, 8'hA5, 1);
    io_write(8'h80, 8'h34, 1);
    exp_at(S_SCR0, 16'h0, 1); io_write(8'h81, 8'h02, 1);
    tick(2);

    // Vblank edge coinciding with a layer-1 write; interrupt request
    exp_at(S_SCR1, 16'h0, 0);
    LVBL = 1'b0;
    exp_at(S_SCR0, 16'h234, 1); exp_at(S_SCR1, 16'h077, 1); exp_at(S_INT, 16'h0, 1);
    exp_at(S_INT, 16'h0, 5);
    io_write(8'h82, 8'h77, 1);
    tick(4);
    // Acknowledge
    exp_at(S_INT, 16'h1, 1);
    bus.iorq_n = 1'b0; bus.m1_n = 1'b0;
    tick(1);
    bus_idle();
    tick(1);
    // Write inside vblank stays in the shadow
    exp_at(S_SCR0, 16'h234, 1); io_write(8'h80, 8'h55, 1);
    LVBL = 1'b1;
    tick(2);
    // Paused: no interrupt, scroll still latched
    dip_pause = 1'b0; LVBL = 1'b0;
    exp_at(S_INT, 16'h1, 1); exp_at(S_INT, 16'h1, 3); exp_at(S_SCR0, 16'h255, 1);
    tick(4);
    LVBL = 1'b1; dip_pause = 1'b1;
    tick(2);

    // Auto-clear after 8 cen pulses
    LVBL = 1'b0;
    exp_at(S_INT, 16'h0, 1);
    tick(1);
    LVBL = 1'b1;
    tick(1);
    for (int i = 1; i <= 8; i++) begin
      exp_at(S_INT, (i == 8) ? 16'h1 : 16'h0, 1);
      cen = 1'b1;
      tick(1);
      cen = 1'b0;
      tick(1);
    end

    // Flip and coin counters
    flip_dip = 1'b1;
    exp_at(S_FLIP, 16'h1, 0);
    exp_at(S_FLIP, 16'h0, 1); io_write(8'h01, 8'h01, 1);
    exp_at(S_FLIP, 16'h1, 1); exp_at(S_COIN, 16'h3, 1); io_write(8'h01, 8'h06, 1);
    checks++;
    if (coin_cnt === 2'd3) passes++;
    else $display("FAIL coin_cnt direct: got %h want 3", coin_cnt);
    exp_at(S_DOUT, 16'h11, 1); io_read(8'h00, 1);

    // Reset in the middle of a write cycle
    exp_at(S_BANK, 16'h3, 1);
    bus.A = 8'h04; bus.din = 8'h03; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick(2);
    rst = 1'b1;
    exp_at(S_BANK, 16'h0, 0); exp_at(S_COIN, 16'h0, 0); exp_at(S_FLIP, 16'h1, 0);
    exp_at(S_SND, 16'h0, 0);  exp_at(S_SCR0, 16'h0, 0); exp_at(S_SCR1, 16'h0, 0);
    exp_at(S_COL, 16'h0, 0);  exp_at(S_DOUT, 16'hFF, 0); exp_at(S_INT, 16'h1, 0);
    tick(1);
    bus_idle();
    tick(1);
    rst = 1'b0;
    tick(2);
    exp_at(S_BANK, 16'h0, 0);
    tick(3);
    checks++;
    if (bank === 3'd0 && int_n === 1'b1) passes++;
    else $display("FAIL post-reset direct: got bank %h int_n %b want 0 1", bank, int_n);

    foreach (sbq[i]) begin
      checks++;
      $display("FAIL unchecked %s: got none want %h at cyc %0d", sbq[i].sig.name(), sbq[i].val, sbq[i].cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
